// File: rtl/pio_edge_capture_in.sv
// Debounced edge-capture parallel input port with an Avalon-MM slave interface.
// Each input bit is synchronised, debounced, and edge-detected. Detected edges
// latch into a write-1-to-clear capture register, which drives a masked,
// level-sensitive interrupt.
//
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   address       word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect    slave select; a write needs chipselect=1 and write_n=0
//   write_n       active-low write strobe
//   writedata     write data (the low WIDTH bits are used)
//   in_port       asynchronous external inputs
//   readdata      registered read data for the current address, 1-cycle latency
//   irq           OR of edgecapture & irqmask, taken directly from registers
module pio_edge_capture_in #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] captured;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ec_clear;
    logic [WIDTH-1:0] ec_next;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry information.
    assign unused_wdata = ^writedata;

    // Per-bit debounce: a new level must persist for DEBOUNCE cycles at sync2.
    always_comb begin
        commit = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    commit[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
        stable_next = stable ^ commit;
    end

    // Edge qualification happens on the commit, against the old stable value.
    always_comb begin
        captured = '0;
        if (EDGE_TYPE == 0) begin
            captured = commit & sync2 & ~stable;
        end else if (EDGE_TYPE == 1) begin
            captured = commit & ~sync2 & stable;
        end else begin
            captured = commit;
        end
    end

    // Bus decode; a fresh capture wins over a same-cycle W1C clear.
    always_comb begin
        wr_en    = chipselect & ~write_n;
        ec_clear = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        ec_next  = (edgecapture & ~ec_clear) | captured;
        case (address)
            2'd0:    rd_next = 32'(stable);
            2'd2:    rd_next = 32'(irqmask);
            2'd3:    rd_next = 32'(edgecapture);
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            stable      <= stable_next;
            edgecapture <= ec_next;
            readdata    <= rd_next;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Directed bench for pio_edge_capture_in: three instances cover rising,
// falling and any-edge capture with WIDTH=8, DEBOUNCE=4.
module tb_pio_edge_capture_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs0, cs1, cs2;
    logic [7:0]  in0, in1, in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_edge_capture_in #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0));

    pio_edge_capture_in #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1));

    pio_edge_capture_in #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle write on dut0.
    task automatic wr0(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs0       = 1'b1;
        write_n   = 1'b0;
        tick(1);
        cs0       = 1'b0;
        write_n   = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
        tick(2);
        check("reset_rd", rd0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // 0x00 -> 0x05 sampled at edge k; visible on readdata at k+6.
        in0 = 8'h05;
        tick(6);
        check("data_before_k6", rd0, 32'h0);
        tick(1);
        check("data_at_k6", rd0, 32'h05);
        address = 2'd3;
        tick(1);
        check("ec_rise", rd0, 32'h05);
        check("irq_unmasked", {31'b0, irq0}, 32'h0);

        // Mask bit 0 raises irq immediately after the write edge.
        wr0(2'd2, 32'h01);
        check("irq_masked", {31'b0, irq0}, 32'h1);
        tick(1);
        check("irqmask_rd", rd0, 32'h01);

        // W1C bit 0.
        wr0(2'd3, 32'h01);
        check("irq_after_w1c", {31'b0, irq0}, 32'h0);
        tick(1);
        check("ec_after_w1c", rd0, 32'h04);

        // 3-cycle glitch on bit 3 is filtered.
        address = 2'd0;
        in0 = 8'h0D;
        tick(3);
        in0 = 8'h05;
        tick(8);
        check("glitch_data", rd0, 32'h05);
        check("glitch_irq", {31'b0, irq0}, 32'h0);
        address = 2'd3;
        tick(1);
        check("glitch_ec", rd0, 32'h04);

        // Drop bit 2, clear its capture, then rise again with a W1C on the commit edge.
        in0 = 8'h01;
        tick(8);
        wr0(2'd3, 32'h04);
        tick(1);
        check("ec_cleared", rd0, 32'h0);
        in0 = 8'h05;
        tick(5);
        wr0(2'd3, 32'h04);
        check("ec_read_precapture", rd0, 32'h0);
        tick(1);
        check("ec_set_priority", rd0, 32'h04);

        // Falling-only and any-edge instances.
        in1 = 8'hFF;
        in2 = 8'h01;
        tick(10);
        check("fall_ignores_rise", rd1, 32'h0);
        check("any_rise", rd2, 32'h01);
        in1 = 8'h7F;
        in2 = 8'h00;
        tick(10);
        check("fall_capture", rd1, 32'h80);
        check("any_fall_stays", rd2, 32'h01);

        // Build edgecapture=0x33 with irqmask=0xFF, then reset mid-operation.
        in0 = 8'h00;
        tick(8);
        wr0(2'd3, 32'hFF);
        wr0(2'd2, 32'hFF);
        in0 = 8'h33;
        tick(8);
        address = 2'd3;
        tick(1);
        check("ec_33", rd0, 32'h33);
        check("irq_33", {31'b0, irq0}, 32'h1);

        reset_n = 1'b0;
        tick(1);              // edge R
        reset_n = 1'b1;
        check("rst_rd", rd0, 32'h0);
        check("rst_irq", {31'b0, irq0}, 32'h0);
        address = 2'd2;
        tick(1);              // R+1
        check("rst_irqmask", rd0, 32'h0);
        address = 2'd3;
        tick(1);              // R+2
        check("rst_ec", rd0, 32'h0);
        tick(4);              // R+6: commit happens here, readdata still old
        check("post_rst_ec_early", rd0, 32'h0);
        tick(1);              // R+7
        check("post_rst_ec_rise", rd0, 32'h33);
        check("post_rst_irq", {31'b0, irq0}, 32'h0);
        address = 2'd0;
        tick(1);
        check("post_rst_data", rd0, 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
